// File: rtl/ray_tracer.sv
// Bresenham ray walker: turns one laser ray into a stream of grid cell updates,
// free cells along the beam followed by a single occupied update at the hit cell.
module ray_tracer #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ray_valid,
    output logic               ray_ready,
    input  logic [X_WIDTH-1:0] x0,
    input  logic [Y_WIDTH-1:0] y0,
    input  logic [X_WIDTH-1:0] x1,
    input  logic [Y_WIDTH-1:0] y1,
    output logic               update_valid,
    input  logic               update_ready,
    output logic [X_WIDTH-1:0] cell_x,
    output logic [Y_WIDTH-1:0] cell_y,
    output logic               cell_is_free,
    output logic               update_last,
    output logic               busy
);
    localparam int D_W   = X_WIDTH + 1;
    localparam int ERR_W = D_W + 2;
    localparam int E2_W  = ERR_W + 1;

    typedef enum logic [1:0] {IDLE, SETUP, TRACE, HIT} state_t;

    state_t                    state_q, state_d;
    logic [X_WIDTH-1:0]        x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d, cell_x_q, cell_x_d;
    logic [Y_WIDTH-1:0]        y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d, cell_y_q, cell_y_d;
    logic signed [D_W-1:0]     dx_q, dx_d, dy_q, dy_d;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic                      sx_q, sx_d, sy_q, sy_d;
    logic                      ray_ready_q, ray_ready_d, update_valid_q, update_valid_d;
    logic                      cell_is_free_q, cell_is_free_d, update_last_q, update_last_d;
    logic                      busy_q, busy_d;

    logic [X_WIDTH-1:0]        dx_abs, nx;
    logic [Y_WIDTH-1:0]        dy_abs, ny;
    logic signed [D_W-1:0]     dx_s, dy_s;
    logic signed [ERR_W-1:0]   dx_err, dy_err, err_n;
    logic signed [E2_W-1:0]    e2, dx_e2, dy_e2;
    logic                      step_x, step_y;

    always_comb begin
        dx_abs = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        dy_abs = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        dx_s   = signed'({1'b0, dx_abs});
        dy_s   = -signed'({{(D_W-Y_WIDTH){1'b0}}, dy_abs});
        dx_err = {{(ERR_W-D_W){dx_q[D_W-1]}}, dx_q};
        dy_err = {{(ERR_W-D_W){dy_q[D_W-1]}}, dy_q};
        dx_e2  = {{(E2_W-D_W){dx_q[D_W-1]}}, dx_q};
        dy_e2  = {{(E2_W-D_W){dy_q[D_W-1]}}, dy_q};
        e2     = {err_q, 1'b0};
        // Both decisions use the pre-update error, so a diagonal step may take both.
        step_x = (e2 >= dy_e2);
        step_y = (e2 <= dx_e2);
        err_n  = err_q + (step_x ? dy_err : '0) + (step_y ? dx_err : '0);
        nx     = step_x ? (sx_q ? cur_x_q + X_WIDTH'(1) : cur_x_q - X_WIDTH'(1)) : cur_x_q;
        ny     = step_y ? (sy_q ? cur_y_q + Y_WIDTH'(1) : cur_y_q - Y_WIDTH'(1)) : cur_y_q;
    end

    always_comb begin
        state_d        = state_q;
        x0_d           = x0_q;
        y0_d           = y0_q;
        x1_d           = x1_q;
        y1_d           = y1_q;
        dx_d           = dx_q;
        dy_d           = dy_q;
        sx_d           = sx_q;
        sy_d           = sy_q;
        err_d          = err_q;
        cur_x_d        = cur_x_q;
        cur_y_d        = cur_y_q;
        ray_ready_d    = ray_ready_q;
        update_valid_d = update_valid_q;
        cell_x_d       = cell_x_q;
        cell_y_d       = cell_y_q;
        cell_is_free_d = cell_is_free_q;
        update_last_d  = update_last_q;
        busy_d         = busy_q;
        case (state_q)
            IDLE: begin
                ray_ready_d    = 1'b1;
                update_valid_d = 1'b0;
                busy_d         = 1'b0;
                if (ray_valid && ray_ready_q) begin
                    x0_d        = x0;
                    y0_d        = y0;
                    x1_d        = x1;
                    y1_d        = y1;
                    ray_ready_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                dx_d    = dx_s;
                dy_d    = dy_s;
                sx_d    = (x0_q < x1_q);
                sy_d    = (y0_q < y1_q);
                err_d   = {{(ERR_W-D_W){dx_s[D_W-1]}}, dx_s} + {{(ERR_W-D_W){dy_s[D_W-1]}}, dy_s};
                cur_x_d = x0_q;
                cur_y_d = y0_q;
                state_d = (x0_q == x1_q && y0_q == y1_q) ? HIT : TRACE;
            end
            TRACE: begin
                // First cycle in TRACE only presents the start cell; stepping follows transfers.
                if (!update_valid_q) begin
                    update_valid_d = 1'b1;
                    cell_x_d       = cur_x_q;
                    cell_y_d       = cur_y_q;
                    cell_is_free_d = 1'b1;
                    update_last_d  = 1'b0;
                end else if (update_ready) begin
                    err_d   = err_n;
                    cur_x_d = nx;
                    cur_y_d = ny;
                    if (nx == x1_q && ny == y1_q) begin
                        state_d        = HIT;
                        cell_x_d       = x1_q;
                        cell_y_d       = y1_q;
                        cell_is_free_d = 1'b0;
                        update_last_d  = 1'b1;
                    end else begin
                        cell_x_d = nx;
                        cell_y_d = ny;
                    end
                end
            end
            HIT: begin
                if (!update_valid_q) begin
                    update_valid_d = 1'b1;
                    cell_x_d       = x1_q;
                    cell_y_d       = y1_q;
                    cell_is_free_d = 1'b0;
                    update_last_d  = 1'b1;
                end else if (update_ready) begin
                    update_valid_d = 1'b0;
                    update_last_d  = 1'b0;
                    busy_d         = 1'b0;
                    ray_ready_d    = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            x0_q           <= '0;
            y0_q           <= '0;
            x1_q           <= '0;
            y1_q           <= '0;
            dx_q           <= '0;
            dy_q           <= '0;
            sx_q           <= 1'b0;
            sy_q           <= 1'b0;
            err_q          <= '0;
            cur_x_q        <= '0;
            cur_y_q        <= '0;
            ray_ready_q    <= 1'b0;
            update_valid_q <= 1'b0;
            cell_x_q       <= '0;
            cell_y_q       <= '0;
            cell_is_free_q <= 1'b0;
            update_last_q  <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            x0_q           <= x0_d;
            y0_q           <= y0_d;
            x1_q           <= x1_d;
            y1_q           <= y1_d;
            dx_q           <= dx_d;
            dy_q           <= dy_d;
            sx_q           <= sx_d;
            sy_q           <= sy_d;
            err_q          <= err_d;
            cur_x_q        <= cur_x_d;
            cur_y_q        <= cur_y_d;
            ray_ready_q    <= ray_ready_d;
            update_valid_q <= update_valid_d;
            cell_x_q       <= cell_x_d;
            cell_y_q       <= cell_y_d;
            cell_is_free_q <= cell_is_free_d;
            update_last_q  <= update_last_d;
            busy_q         <= busy_d;
        end
    end

    assign ray_ready    = ray_ready_q;
    assign update_valid = update_valid_q;
    assign cell_x       = cell_x_q;
    assign cell_y       = cell_y_q;
    assign cell_is_free = cell_is_free_q;
    assign update_last  = update_last_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_ray_tracer.sv
// Directed bench for ray_tracer: table of rays with hand-computed counts and cells,
// a software Bresenham reference for full sequences, plus reset and busy corner cases.
module tb_ray_tracer;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ray_valid = 1'b0;
    logic       update_ready = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic       ray_ready, update_valid, cell_is_free, update_last, busy;
    logic [7:0] cell_x;
    logic [6:0] cell_y;

    ray_tracer #(.X_WIDTH(8), .Y_WIDTH(7)) dut (
        .clock(clock), .reset(reset), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .update_valid(update_valid), .update_ready(update_ready),
        .cell_x(cell_x), .cell_y(cell_y), .cell_is_free(cell_is_free),
        .update_last(update_last), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic       free;
        logic       last;
    } upd_t;

    typedef struct {
        int x0; int y0; int x1; int y1;
        bit rnd;
        int cnt;
        int mid_i; int mid_x; int mid_y;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   rr_seen;
    upd_t got_q[$];
    upd_t exp_q[$];
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, dx, dy, sx, sy, err, e2;
        upd_t u;
        exp_q.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        x   = ax0;
        y   = ay0;
        for (int k = 0; k < 400; k++) begin
            u.x = 8'(x);
            u.y = 7'(y);
            if (x == ax1 && y == ay1) begin
                u.free = 1'b0;
                u.last = 1'b1;
                exp_q.push_back(u);
                break;
            end
            u.free = 1'b1;
            u.last = 1'b0;
            exp_q.push_back(u);
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic wait_accept(output int waited);
        waited = 0;
        while (ray_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 50) chk("accept_timeout", 1, 0);
        @(negedge clock);
        ray_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (update_valid !== 1'b1 && lat < 10) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic collect(input bit rnd);
        upd_t cur, prev;
        bit   stalled, done;
        int   n;
        got_q.delete();
        rr_seen = 0;
        stalled = 1'b0;
        done    = 1'b0;
        prev    = '0;
        for (n = 0; n < 3000 && !done; n++) begin
            update_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ray_ready) rr_seen++;
            if (update_valid) begin
                cur.x    = cell_x;
                cur.y    = cell_y;
                cur.free = cell_is_free;
                cur.last = update_last;
                if (stalled) chk("stall_hold", int'(cur), int'(prev));
                if (update_ready) begin
                    got_q.push_back(cur);
                    if (update_last) done = 1'b1;
                end
                stalled = !update_ready;
                prev    = cur;
            end else begin
                if (stalled) chk("valid_dropped_in_stall", 0, 1);
                stalled = 1'b0;
            end
            @(negedge clock);
        end
        update_ready = 1'b0;
        if (!done) chk("collect_timeout", 1, 0);
        chk("ray_ready_while_busy", rr_seen, 0);
    endtask

    task automatic compare_model(input int ax0, input int ay0, input int ax1, input int ay1);
        int bad;
        model(ax0, ay0, ax1, ay1);
        chk("model_count", got_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (got_q[i] != exp_q[i] && bad < 0) bad = i;
        end
        chk("model_seq_first_bad_index", bad, -1);
    endtask

    task automatic do_ray(input vec_t v);
        int waited, lat, n_occ;
        x0 = 8'(v.x0); y0 = 7'(v.y0); x1 = 8'(v.x1); y1 = 7'(v.y1);
        ray_valid = 1'b1;
        wait_accept(waited);
        chk("busy_after_accept", busy, 1);
        wait_valid(lat);
        chk("first_valid_latency", lat, 2);
        collect(v.rnd);
        chk("ready_after_hit", ray_ready, 1);
        chk("valid_after_hit", update_valid, 0);
        chk("busy_after_hit", busy, 0);
        chk("update_count", got_q.size(), v.cnt);
        if (got_q.size() > v.mid_i) begin
            chk("mid_cell_x", got_q[v.mid_i].x, v.mid_x);
            chk("mid_cell_y", got_q[v.mid_i].y, v.mid_y);
        end else begin
            chk("mid_cell_missing", 1, 0);
        end
        n_occ = 0;
        foreach (got_q[i]) if (!got_q[i].free) n_occ++;
        chk("occupied_count", n_occ, 1);
        if (got_q.size() > 0) begin
            chk("end_x", got_q[got_q.size()-1].x, v.x1);
            chk("end_y", got_q[got_q.size()-1].y, v.y1);
            chk("end_last", got_q[got_q.size()-1].last, 1);
        end
        compare_model(v.x0, v.y0, v.x1, v.y1);
        $display("[TB] ray (%0d,%0d)->(%0d,%0d) rnd=%0d: %0d updates", v.x0, v.y0, v.x1, v.y1,
                 v.rnd, got_q.size());
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, lat, seen, n;
        vecs[0] = '{10, 5, 14, 5, 1'b0, 5, 2, 12, 5};
        vecs[1] = '{20, 30, 17, 27, 1'b0, 4, 1, 19, 29};
        vecs[2] = '{7, 7, 7, 7, 1'b0, 1, 0, 7, 7};
        vecs[3] = '{0, 0, 255, 127, 1'b1, 256, 2, 2, 1};
        vecs[4] = '{1, 1, 3, 1, 1'b0, 3, 1, 2, 1};
        vecs[5] = '{100, 50, 90, 60, 1'b1, 11, 5, 95, 55};
        vecs[6] = '{5, 100, 6, 0, 1'b0, 101, 50, 6, 50};
        vecs[7] = '{255, 0, 0, 127, 1'b1, 256, 2, 253, 1};

        repeat (3) @(negedge clock);
        chk("reset_ray_ready", ray_ready, 0);
        chk("reset_update_valid", update_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_cell", int'({cell_x, cell_y, cell_is_free, update_last}), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_reset", ray_ready, 1);

        for (int i = 0; i < 8; i++) do_ray(vecs[i]);

        // Reset after the third transfer of a long ray.
        x0 = 8'd0; y0 = 7'd0; x1 = 8'd50; y1 = 7'd10;
        ray_valid = 1'b1;
        wait_accept(waited);
        update_ready = 1'b1;
        got_q.delete();
        n = 0;
        while (got_q.size() < 3 && n < 50) begin
            if (update_valid) got_q.push_back({cell_x, cell_y, cell_is_free, update_last});
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk("reset_test_timeout", 1, 0);
        update_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        chk("midray_reset_valid", update_valid, 0);
        chk("midray_reset_busy", busy, 0);
        chk("midray_reset_ready", ray_ready, 0);
        reset = 1'b0;
        @(negedge clock);
        chk("ready_after_midray_reset", ray_ready, 1);
        seen = 0;
        update_ready = 1'b1;
        repeat (4) begin
            if (update_valid) seen++;
            @(negedge clock);
        end
        update_ready = 1'b0;
        chk("no_update_after_reset", seen, 0);
        model(0, 0, 50, 10);
        for (int i = 0; i < 3; i++) chk("pre_reset_cell", int'(got_q[i]), int'(exp_q[i]));
        $display("[TB] ray (0,0)->(50,10) reset after 3 updates");
        do_ray('{1, 1, 3, 1, 1'b0, 3, 1, 2, 1});

        // A second ray held on the inputs while busy must wait for the IDLE cycle.
        x0 = 8'd1; y0 = 7'd1; x1 = 8'd4; y1 = 7'd1;
        ray_valid = 1'b1;
        wait_accept(waited);
        x0 = 8'd9; y0 = 7'd9; x1 = 8'd9; y1 = 7'd9;
        ray_valid = 1'b1;
        collect(1'b0);
        chk("idle_cycle_ready", ray_ready, 1);
        chk("busy_ray_count", got_q.size(), 4);
        if (got_q.size() > 0) chk("busy_ray_first_x", got_q[0].x, 1);
        compare_model(1, 1, 4, 1);
        $display("[TB] ray (1,1)->(4,1) with pending ray: %0d updates", got_q.size());
        wait_accept(waited);
        chk("pending_accept_wait", waited, 0);
        wait_valid(lat);
        chk("pending_latency", lat, 2);
        collect(1'b0);
        chk("pending_count", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("pending_update", int'(got_q[0]), int'({8'd9, 7'd9, 1'b0, 1'b1}));
        $display("[TB] pending ray (9,9)->(9,9): %0d updates", got_q.size());

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ray_tracer.md
Name: ray_tracer

Overview:
- Upstream feeder for the occupancy grid datapath.
- Takes one laser ray, given as a robot cell (x0,y0) and a beam endpoint cell (x1,y1) on the 256x128 grid.
- Walks the cells between them with Bresenham's integer line algorithm. Each traversed cell is emitted as a "free" update; the endpoint is emitted as one final "occupied" update.
- The grid controller consumes each update as the x/y/cell_is_free/write_enable inputs of the occupancy datapath.

Parameters:
- X_WIDTH, 8, grid column index width (0..255)
- Y_WIDTH, 7, grid row index width (0..127)

Ports:
- clock  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- ray_valid  in  1  ray endpoints on x0/y0/x1/y1 are valid
- ray_ready  out  1  tracer idle and able to accept a ray
- x0  in  X_WIDTH  ray start column (robot cell)
- y0  in  Y_WIDTH  ray start row
- x1  in  X_WIDTH  ray end column (beam hit cell)
- y1  in  Y_WIDTH  ray end row
- update_valid  out  1  cell_x/cell_y/cell_is_free hold a pending update
- update_ready  in  1  grid controller accepts the current update this cycle
- cell_x  out  X_WIDTH  column of update
- cell_y  out  Y_WIDTH  row of update
- cell_is_free  out  1  1 = decrement (free), 0 = increment (occupied)
- update_last  out  1  marks the endpoint update, the final one of the ray
- busy  out  1  ray in progress (state != IDLE)

Behaviour:
- Reset values: all outputs registered. On reset, every output is 0, the state is IDLE and the internal registers are 0.
- ray_ready rises on the first edge after reset deasserts.
- Reset mid-ray: the current ray is dropped and update_valid is 0 from the next edge. No partial endpoint update is emitted.
- State IDLE: ray_ready=1, update_valid=0. On ray_valid & ray_ready at edge E:
  - latch x0,y0,x1,y1;
  - drop ray_ready;
  - set busy=1;
  - go to SETUP.
- State SETUP (one cycle):
  - dx = |x1-x0| (9-bit signed), dy = -|y1-y0| (9-bit signed);
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1;
  - err = dx+dy (11-bit signed);
  - cur = (x0,y0).
  - If cur == (x1,y1), go to HIT; otherwise go to TRACE.
  - update_valid first rises after edge E+2.
- State TRACE: outputs are cell=cur, cell_is_free=1, update_last=0, update_valid=1. On update_ready:
  - e2 = 2*err (12-bit signed);
  - if e2 >= dy: err += dy, cur_x += sx;
  - if e2 <= dx: err += dx, cur_y += sy (both branches may fire in the same cycle, using the pre-update err);
  - if the new cur == (x1,y1), go to HIT, else stay in TRACE with the new cell presented on the next cycle.
- State HIT: outputs are cell=(x1,y1), cell_is_free=0, update_last=1, update_valid=1.
  - On update_ready: update_valid=0, update_last=0, busy=0, ray_ready=1 from the next edge, go to IDLE.
- Handshake:
  - An update transfers on a clock edge where update_valid & update_ready.
  - While update_valid=1 & update_ready=0, cell_x, cell_y, cell_is_free and update_last hold stable.
  - Throughput is one update per cycle while update_ready stays high.
- Count: one ray produces exactly max(|x1-x0|,|y1-y0|)+1 updates, of which the last is the only occupied one.
- Zero-length ray (start == end): exactly one update, occupied, with update_last=1.
- Coordinates never leave the bounding box of the two endpoints. No wrap-around is possible and no clamping is needed.
- The maximum ray (0,0)->(255,127) produces 256 updates.
- Back-to-back rays: minimum one IDLE cycle between the last update of one ray and acceptance of the next.
- ray_valid while busy is ignored (no capture); the source holds the ray until ray_ready.

Test Plan:
- Ray (10,5)->(14,5), update_ready tied 1 -> updates (10,5),(11,5),(12,5),(13,5) with cell_is_free=1, then (14,5) with free=0 and last=1 on consecutive cycles. First valid 2 cycles after acceptance.
- Ray (20,30)->(17,27) -> (20,30),(19,29),(18,28) free, then (17,27) occupied. Checks negative steps and diagonal dual-step.
- Ray (7,7)->(7,7) -> exactly one update (7,7), free=0, last=1; ray_ready returns high next edge.
- Ray (0,0)->(255,127) with update_ready toggling randomly -> 256 transfers. Outputs are stable during stalls and the final cell is (255,127) with last=1; cross-check the cell sequence against a software Bresenham model.
- Assert reset for one cycle after the 3rd update of ray (0,0)->(50,10) -> update_valid=0 next edge, no occupied update is emitted, and ray_ready=1 the edge after reset drops. A following ray (1,1)->(3,1) traces correctly.
- Drive ray_valid with a new ray while busy -> ignored; it is accepted only after the prior HIT transfer plus one IDLE cycle.
